// File: rtl/rgb_to_edgein_pkg.sv
// Shared luma constants and pipeline stage bundles for the RGB to edge-input path.
package rgb_to_edgein_pkg;

  localparam int LUMA_KR = 77;
  localparam int LUMA_KG = 150;
  localparam int LUMA_KB = 29;
  localparam int LUMA_SHIFT = 8;
  localparam logic [7:0] EDGE_WHITE = 8'hFF;

  typedef struct packed {
    logic        valid;
    logic        sof;
    logic        eol;
    logic [15:0] pr;
    logic [15:0] pg;
    logic [15:0] pb;
  } s1_t;

  typedef struct packed {
    logic        valid;
    logic        sof;
    logic        eol;
    logic [15:0] sum;
  } s2_t;

  function automatic logic [7:0] luma_of(input logic [15:0] sum);
    return sum[LUMA_SHIFT+7:LUMA_SHIFT];
  endfunction

endpackage

// File: rtl/luma_mac.sv
// Luma multiply (S1) and accumulate (S2) stages.
// Both stages load together whenever en is high.
module luma_mac
  import rgb_to_edgein_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic        in_eol,
  input  logic [23:0] in_rgb,
  output s2_t         s2
);

  s1_t s1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else if (en) begin
      s1.valid <= in_valid;
      s1.sof   <= in_sof;
      s1.eol   <= in_eol;
      s1.pr    <= 16'(LUMA_KR) * {8'd0, in_rgb[23:16]};
      s1.pg    <= 16'(LUMA_KG) * {8'd0, in_rgb[15:8]};
      s1.pb    <= 16'(LUMA_KB) * {8'd0, in_rgb[7:0]};
      s2.valid <= s1.valid;
      s2.sof   <= s1.sof;
      s2.eol   <= s1.eol;
      // 255*256 is the ceiling, so 16 bits never overflow
      s2.sum   <= s1.pr + s1.pg + s1.pb;
    end
  end

endmodule

// File: rtl/rgb_to_edgein.sv
// RGB pixel stream to whitened 8-bit luma for the edge detector.
// Three-stage pipeline with a global stall and a per-line pixel counter.
module rgb_to_edgein
  import rgb_to_edgein_pkg::*;
#(
  parameter logic [7:0] WHITE_THRESH = 8'hF0,
  parameter int         CNT_W        = 11
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [23:0]      in_rgb,
  input  logic             in_sof,
  input  logic             in_eol,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_pix,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] px_count
);

  s2_t        s2;
  logic       advance;
  logic       xfer;
  logic       last_eol;
  logic [7:0] y;

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;
  assign xfer     = out_valid & out_ready;
  assign y        = luma_of(s2.sum);

  luma_mac u_mac (
    .clock    (clock),
    .reset_n  (reset_n),
    .en       (advance),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_eol   (in_eol),
    .in_rgb   (in_rgb),
    .s2       (s2)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (advance) begin
      out_valid <= s2.valid;
      out_pix   <= (y >= WHITE_THRESH) ? EDGE_WHITE : y;
      out_sof   <= s2.sof;
      out_eol   <= s2.eol;
    end
  end

  // Count restarts on frame start or on the pixel after a line end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      px_count <= '0;
      last_eol <= 1'b0;
    end else if (xfer) begin
      last_eol <= out_eol;
      if (out_sof || last_eol)
        px_count <= CNT_W'(1);
      else if (px_count != '1)
        px_count <= px_count + 1'b1;
    end
  end

endmodule
